// File: rtl/serial_frame_tx_if.sv
// Producer/consumer bundle for the serial frame transmitter: word request in, serial frame and status out.
interface serial_frame_tx_if #(
   parameter int WIDTH = 8
);
   logic             Start;
   logic [WIDTH-1:0] Data_in;
   logic             Dout;
   logic             Dout_valid;
   logic             Busy;
   logic             Done;

   modport master (
      output Start, Data_in,
      input  Dout, Dout_valid, Busy, Done
   );

   modport slave (
      input  Start, Data_in,
      output Dout, Dout_valid, Busy, Done
   );
endinterface

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: two header ones, WIDTH payload bits MSB-first, one Finish cycle.
// All outputs are registered and decoded from the next state, so they line up with the state they describe.
module serial_frame_tx #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 5
) (
   input  logic              Clock,
   input  logic              Reset,
   serial_frame_tx_if.slave  bus
);

   localparam logic [3:0] S_IDLE    = 4'b0001;
   localparam logic [3:0] S_HEADER  = 4'b0010;
   localparam logic [3:0] S_PAYLOAD = 4'b0100;
   localparam logic [3:0] S_FINISH  = 4'b1000;

   logic [3:0]       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dout_q, dout_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      dout_d  = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               state_d = S_HEADER;
               shift_d = bus.Data_in;
               cnt_d   = '0;
            end
         end
         S_HEADER: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_PAYLOAD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_PAYLOAD: begin
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = S_FINISH;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      // The bit leaving the MSB on this edge is the one shown during the coming payload cycle.
      case (state_d)
         S_HEADER: begin
            dout_d  = 1'b1;
            valid_d = 1'b1;
            busy_d  = 1'b1;
         end
         S_PAYLOAD: begin
            dout_d  = shift_q[WIDTH-1];
            shift_d = shift_q << 1;
            valid_d = 1'b1;
            busy_d  = 1'b1;
         end
         S_FINISH: begin
            busy_d = 1'b1;
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         dout_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.Dout       = dout_q;
   assign bus.Dout_valid = valid_q;
   assign bus.Busy       = busy_q;
   assign bus.Done       = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: a frame-position model checked every cycle, plus literal frame expectations.
module tb_serial_frame_tx;

   localparam int WIDTH = 8;

   logic Clock = 1'b0;
   logic Reset;

   serial_frame_tx_if #(.WIDTH(WIDTH)) bus_if ();

   serial_frame_tx #(.WIDTH(WIDTH), .CNT_W(5)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus_if.slave)
   );

   always #5 Clock = ~Clock;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: position inside the frame (-1 = idle), 0..1 header, 2..WIDTH+1 payload, WIDTH+2 finish.
   int               cyc      = 0;
   int               pos      = -1;
   int               abort_at = -1;
   logic [WIDTH-1:0] word     = '0;

   always @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         pos = -1;
      end else begin
         cyc++;
         if (cyc == abort_at) pos = -1;
         else if (pos < 0) begin
            if (bus_if.Start === 1'b1) begin
               pos  = 0;
               word = bus_if.Data_in;
            end
         end else begin
            pos++;
            if (pos == WIDTH + 3) pos = -1;
         end
      end
   end

   always @(negedge Clock) begin
      logic e_dout;
      int   b;
      e_dout = 1'b0;
      if (pos == 0 || pos == 1) e_dout = 1'b1;
      else if (pos >= 2 && pos <= WIDTH + 1) begin
         b      = WIDTH - 1 - (pos - 2);
         e_dout = word[b];
      end
      check("dout",       32'(bus_if.Dout),       32'(e_dout));
      check("dout_valid", 32'(bus_if.Dout_valid), 32'(pos >= 0 && pos <= WIDTH + 1));
      check("busy",       32'(bus_if.Busy),       32'(pos >= 0));
      check("done",       32'(bus_if.Done),       32'(pos == WIDTH + 2));
   end

   // Monitor: cycle-stamped record of valid bits, Done and Busy cycles.
   typedef struct {
      int   stamp;
      logic b;
   } vrec_t;
   vrec_t vq[$];
   int    dq[$];
   int    bq[$];

   always @(negedge Clock) begin
      vrec_t rec;
      if (bus_if.Dout_valid === 1'b1) begin
         rec.stamp = cyc;
         rec.b     = bus_if.Dout;
         vq.push_back(rec);
      end
      if (bus_if.Done === 1'b1) dq.push_back(cyc);
      if (bus_if.Busy === 1'b1) bq.push_back(cyc);
   end

   // Sticky two-ones detector on the valid bit stream, cleared between frames.
   logic det  = 1'b0;
   logic prev = 1'b0;
   always @(posedge Clock) begin
      if (bus_if.Busy !== 1'b1) begin
         det  <= 1'b0;
         prev <= 1'b0;
      end else if (bus_if.Dout_valid === 1'b1) begin
         if (prev && bus_if.Dout) det <= 1'b1;
         prev <= bus_if.Dout;
      end
   end

   function automatic logic [WIDTH+1:0] frame_bits(input int k);
      logic [WIDTH+1:0] r;
      r = 'x;
      foreach (vq[i])
         if (vq[i].stamp >= k && vq[i].stamp <= k + WIDTH + 1)
            r[WIDTH + 1 - (vq[i].stamp - k)] = vq[i].b;
      return r;
   endfunction

   function automatic int n_done(input int lo, input int hi);
      int n = 0;
      foreach (dq[i]) if (dq[i] >= lo && dq[i] <= hi) n++;
      return n;
   endfunction

   function automatic int n_busy(input int lo, input int hi);
      int n = 0;
      foreach (bq[i]) if (bq[i] >= lo && bq[i] <= hi) n++;
      return n;
   endfunction

   function automatic int n_valid(input int lo, input int hi);
      int n = 0;
      foreach (vq[i]) if (vq[i].stamp >= lo && vq[i].stamp <= hi) n++;
      return n;
   endfunction

   // Drives a one-cycle Start; k is the stamp of the first header cycle.
   task automatic send(input logic [WIDTH-1:0] d, output int k);
      @(negedge Clock);
      bus_if.Data_in = d;
      bus_if.Start   = 1'b1;
      k = cyc + 1;
      @(negedge Clock);
      bus_if.Start = 1'b0;
   endtask

   task automatic wait_stamp(input int s);
      while (cyc < s) @(negedge Clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, k1, k2;
      Reset          = 1'b1;
      bus_if.Start   = 1'b0;
      bus_if.Data_in = '0;

      // Test 1: reset then idle.
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      repeat (5) begin
         @(negedge Clock);
         check("idle_outputs", {28'd0, bus_if.Dout, bus_if.Dout_valid, bus_if.Busy, bus_if.Done}, 32'd0);
      end

      // Test 2: A5 frame, Done in cycle 11, Busy for 11 cycles.
      send(8'hA5, k);
      repeat (13) @(negedge Clock);
      check("frame_a5",      32'(frame_bits(k)), 32'(10'b11_1010_0101));
      check("a5_done_once",  32'(n_done(k, k + 12)), 32'd1);
      check("a5_done_cyc11", 32'(n_done(k + 10, k + 10)), 32'd1);
      check("a5_busy_count", 32'(n_busy(k, k + 12)), 32'd11);
      check("a5_busy_first", 32'(n_busy(k, k)), 32'd1);

      // Test 3: zero payload, two-ones detector fires after header bit 2 and stays high.
      send(8'h00, k);
      check("det_before", 32'(det), 32'd0);
      for (int i = 1; i <= 10; i++) begin
         @(negedge Clock);
         check("det_track", 32'(det), 32'(i >= 2));
      end
      repeat (3) @(negedge Clock);
      check("frame_00",   32'(frame_bits(k)), 32'(10'b11_0000_0000));
      check("00_done",    32'(n_done(k + 10, k + 10)), 32'd1);

      // Test 4: Start held high, Data_in changed mid-frame.
      @(negedge Clock);
      bus_if.Data_in = 8'hFF;
      bus_if.Start   = 1'b1;
      k1 = cyc + 1;
      repeat (4) @(negedge Clock);
      bus_if.Data_in = 8'h3C;
      wait_stamp(k1 + 12);
      bus_if.Start = 1'b0;
      repeat (14) @(negedge Clock);
      check("frame_ff",      32'(frame_bits(k1)), 32'(10'b11_1111_1111));
      check("frame_3c",      32'(frame_bits(k1 + 12)), 32'(10'b11_0011_1100));
      check("ff_done",       32'(n_done(k1 + 10, k1 + 10)), 32'd1);
      check("3c_done",       32'(n_done(k1 + 22, k1 + 22)), 32'd1);
      check("gap_not_busy",  32'(n_busy(k1 + 11, k1 + 11)), 32'd0);
      check("gap_no_valid",  32'(n_valid(k1 + 10, k1 + 11)), 32'd0);

      // Test 5: asynchronous reset during payload bit 3.
      send(8'hA5, k);
      wait_stamp(k + 4);
      check("pre_reset_dout", 32'(bus_if.Dout), 32'd1);
      #2 Reset = 1'b1;
      #1;
      check("async_reset_out", {28'd0, bus_if.Dout, bus_if.Dout_valid, bus_if.Busy, bus_if.Done}, 32'd0);
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      check("reset_no_done", 32'(n_done(k, cyc)), 32'd0);
      send(8'hA5, k2);
      repeat (13) @(negedge Clock);
      check("frame_after_reset", 32'(frame_bits(k2)), 32'(10'b11_1010_0101));
      check("done_after_reset",  32'(n_done(k2 + 10, k2 + 10)), 32'd1);

      // Test 6: illegal state mid-payload recovers to Idle after one edge.
      send(8'hA5, k);
      wait_stamp(k + 3);
      force dut.state_q = 4'b0110;
      abort_at = cyc + 1;
      #1 release dut.state_q;
      @(negedge Clock);
      check("illegal_state_idle", 32'(dut.state_q), 32'(4'b0001));
      check("illegal_outputs", {28'd0, bus_if.Dout, bus_if.Dout_valid, bus_if.Busy, bus_if.Done}, 32'd0);
      repeat (3) @(negedge Clock);
      check("illegal_no_done", 32'(n_done(k, cyc)), 32'd0);
      send(8'h3C, k2);
      repeat (13) @(negedge Clock);
      check("frame_after_illegal", 32'(frame_bits(k2)), 32'(10'b11_0011_1100));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
